// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA transfer controller
package dma_pkg;

  localparam int DMA_WIDTH = 8;

  localparam logic [DMA_WIDTH-1:0] DMA_LEN_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_xfer_ctrl_if.sv
// rtl/dma_xfer_ctrl_if.sv - memory bus bundle between the DMA initiator and mem_bus
interface dma_xfer_ctrl_if
  import dma_pkg::*;
#(
  parameter int WIDTH = DMA_WIDTH
) ();

  logic [WIDTH-1:0] tx_mem_addr;
  logic [WIDTH-1:0] data_tx_out;
  logic [WIDTH-1:0] rx_mem_addr;
  logic [WIDTH-1:0] data_rx_in;
  logic             mem_wr_en;

  modport master (
    output tx_mem_addr,
    output rx_mem_addr,
    output data_rx_in,
    output mem_wr_en,
    input  data_tx_out
  );

  modport slave (
    input  tx_mem_addr,
    input  rx_mem_addr,
    input  data_rx_in,
    input  mem_wr_en,
    output data_tx_out
  );

endinterface

// File: rtl/dma_xfer_ctrl.sv
// rtl/dma_xfer_ctrl.sv - pipelined TX ROM to RX RAM word copier, one word per cycle
// Optional XOR checksum of written words when DMA_CHECKSUM_EN is defined.
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int WIDTH = DMA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src_addr,
  input  logic [WIDTH-1:0] dst_addr,
  input  logic [WIDTH-1:0] xfer_len,
  input  logic             pause,
  dma_xfer_ctrl_if.master  mem,
  output logic             busy,
  output logic             done
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0] checksum
`endif
);

  dma_state_e       state_q, state_d;
  logic [WIDTH-1:0] tx_addr_q, tx_addr_d;
  logic [WIDTH-1:0] rx_addr_q, rx_addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  // Remembers the len=0 path so DONE knows whether it still owes the done pulse.
  logic             zero_q, zero_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_addr_q <= '0;
      rx_addr_q <= '0;
      data_q    <= '0;
      rd_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_addr_q <= tx_addr_d;
      rx_addr_q <= rx_addr_d;
      data_q    <= data_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_addr_d = tx_addr_q;
    rx_addr_d = rx_addr_q;
    data_d    = data_q;
    rd_cnt_d  = rd_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          wr_ptr_d = dst_addr;
          rd_cnt_d = xfer_len;
          if (xfer_len == WIDTH'(DMA_LEN_ZERO)) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            zero_d    = 1'b0;
            tx_addr_d = src_addr;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        // A paused edge leaves everything held and drops the strobe so no write repeats.
        if (!pause) begin
          data_d    = mem.data_tx_out;
          rx_addr_d = wr_ptr_q;
          wr_en_d   = 1'b1;
          tx_addr_d = tx_addr_q + WIDTH'(1);
          wr_ptr_d  = wr_ptr_q + WIDTH'(1);
          rd_cnt_d  = rd_cnt_q - WIDTH'(1);
          if (rd_cnt_q == WIDTH'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!pause) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = zero_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.tx_mem_addr = tx_addr_q;
  assign mem.rx_mem_addr = rx_addr_q;
  assign mem.data_rx_in  = data_q;
  assign mem.mem_wr_en   = wr_en_q;
  assign busy            = busy_q;
  assign done            = done_q;

`ifdef DMA_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q;
  logic             csum_clr;

  assign csum_clr = (state_q == IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst_n || csum_clr) begin
      csum_q <= '0;
    end else if (wr_en_q) begin
      csum_q <= csum_q ^ data_q;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// tb/tb_dma_xfer_ctrl.sv - directed self-checking bench for dma_xfer_ctrl
module tb_dma_xfer_ctrl;
  import dma_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       pause;
  logic [7:0] src;
  logic [7:0] dst;
  logic [7:0] len;
  logic       busy;
  logic       done;
`ifdef DMA_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  dma_xfer_ctrl_if #(.WIDTH(8)) mem ();

  logic [7:0] rom [256];
  assign mem.data_tx_out = rom[mem.tx_mem_addr];

  dma_xfer_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src),
    .dst_addr (dst),
    .xfer_len (len),
    .pause    (pause),
    .mem      (mem),
    .busy     (busy),
    .done     (done)
`ifdef DMA_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0] wa [$];
  logic [7:0] wd [$];

  // RX RAM side: every edge with the strobe high is a committed write.
  always @(posedge clk) begin
    if (mem.mem_wr_en === 1'b1) begin
      wa.push_back(mem.rx_mem_addr);
      wd.push_back(mem.data_rx_in);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    start = 1'b1;
    src   = s;
    dst   = d;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  task automatic check_log(input string tag, input logic [7:0] s, input logic [7:0] d, input int n);
    chk({tag, " write count"}, 32'(wa.size()), 32'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      logic [7:0] ea;
      logic [7:0] es;
      ea = d + 8'(i);
      es = s + 8'(i);
      chk({tag, " write addr"}, 32'(wa[i]), 32'(ea));
      chk({tag, " write data"}, 32'(wd[i]), 32'(rom[es]));
    end
  endtask

  initial begin
    logic [7:0] exp_d [4];
    exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
    rom[8'h10] = 8'hA1; rom[8'h11] = 8'hB2; rom[8'h12] = 8'hC3; rom[8'h13] = 8'hD4;
    rom[8'h70] = 8'h0F; rom[8'h71] = 8'hF0; rom[8'h72] = 8'h55;

    rst_n = 1'b0; start = 1'b0; pause = 1'b0; src = 8'h00; dst = 8'h00; len = 8'h00;
    step();
    step();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset wr_en", 32'(mem.mem_wr_en), 32'd0);
    chk("reset tx_addr", 32'(mem.tx_mem_addr), 32'd0);
    chk("reset rx_addr", 32'(mem.rx_mem_addr), 32'd0);
    chk("reset data", 32'(mem.data_rx_in), 32'd0);
`ifdef DMA_CHECKSUM_EN
    chk("reset checksum", 32'(checksum), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Basic copy, cycle by cycle after the start edge.
    wa.delete(); wd.delete();
    kick(8'h10, 8'h80, 8'd4);
    chk("basic c0 busy", 32'(busy), 32'd1);
    chk("basic c0 tx_addr", 32'(mem.tx_mem_addr), 32'h10);
    chk("basic c0 wr_en", 32'(mem.mem_wr_en), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("basic wr_en", 32'(mem.mem_wr_en), 32'(k >= 1 && k <= 4));
      chk("basic done", 32'(done), 32'(k == 5));
      chk("basic busy", 32'(busy), 32'(k <= 4));
      if (k <= 4) begin
        chk("basic rx_addr", 32'(mem.rx_mem_addr), 32'(8'(8'h80 + k - 1)));
        chk("basic data", 32'(mem.data_rx_in), 32'(exp_d[k-1]));
      end
    end
    check_log("basic", 8'h10, 8'h80, 4);

    // Zero length: no writes, done one cycle after busy.
    wa.delete(); wd.delete();
    kick(8'h10, 8'h33, 8'd0);
    chk("zero c0 busy", 32'(busy), 32'd1);
    chk("zero c0 wr_en", 32'(mem.mem_wr_en), 32'd0);
    wait_done("zero done cycle", 1);
    chk("zero busy at done", 32'(busy), 32'd0);
    step();
    chk("zero done width", 32'(done), 32'd0);
    chk("zero write count", 32'(wa.size()), 32'd0);
    step();

    // Address wrap on both sides.
    wa.delete(); wd.delete();
    kick(8'hFE, 8'hFF, 8'd3);
    wait_done("wrap done cycle", 4);
    chk("wrap tx_addr end", 32'(mem.tx_mem_addr), 32'h01);
    check_log("wrap", 8'hFE, 8'hFF, 3);
    step();

    // Pause for two edges after the second write is presented.
    wa.delete(); wd.delete();
    kick(8'h10, 8'hA0, 8'd4);
    step();
    step();
    chk("pause c2 tx_addr", 32'(mem.tx_mem_addr), 32'h12);
    pause = 1'b1;
    step();
    chk("pause c3 wr_en", 32'(mem.mem_wr_en), 32'd0);
    chk("pause c3 tx_addr", 32'(mem.tx_mem_addr), 32'h12);
    chk("pause c3 busy", 32'(busy), 32'd1);
    chk("pause c3 data hold", 32'(mem.data_rx_in), 32'hB2);
    step();
    pause = 1'b0;
    wait_done("pause done cycle", 3);
    check_log("pause", 8'h10, 8'hA0, 4);
    step();

    // Start re-asserted mid-transfer is ignored.
    wa.delete(); wd.delete();
    kick(8'h20, 8'h40, 8'd4);
    step();
    start = 1'b1; src = 8'h60; dst = 8'h00; len = 8'd2;
    step();
    start = 1'b0;
    wait_done("ignore done cycle", 3);
    check_log("ignore", 8'h20, 8'h40, 4);
    step();

    // Reset mid-transfer aborts without done.
    wa.delete(); wd.delete();
    done_cnt = 0;
    kick(8'h30, 8'h50, 8'd5);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort wr_en", 32'(mem.mem_wr_en), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort tx_addr", 32'(mem.tx_mem_addr), 32'd0);
    for (int k = 0; k < 8; k++) step();
    chk("abort write count", 32'(wa.size()), 32'd2);
    chk("abort done pulses", 32'(done_cnt), 32'd0);
    chk("abort idle busy", 32'(busy), 32'd0);

    // Data pattern used for the checksum; the copy itself is checked in every build.
    wa.delete(); wd.delete();
    kick(8'h70, 8'h90, 8'd3);
    wait_done("csum done cycle", 4);
    check_log("csum", 8'h70, 8'h90, 3);
`ifdef DMA_CHECKSUM_EN
    chk("checksum at done", 32'(checksum), 32'hAA);
`endif
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
